// File: rtl/pc_seq_pkg.sv
// Shared program-flow definitions: opcode constants, fault encodings and sequencer states.
// The instruction register imports the same opcode constants.
package pc_seq_pkg;

  localparam int unsigned OPC_W = 12;
  localparam int unsigned CODE_W = 22;

  localparam logic [OPC_W-1:0]  BSR_OPCODE = 12'b011100000000;
  localparam logic [CODE_W-1:0] RET_CODE   = 22'b0000011000000000000000;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UNF  = 2'b10;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO with a registered depth pointer.
// Storage is not reset; only the depth pointer defines which entries are valid.
module ret_stack #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         top,
  output logic [$clog2(DEPTH):0]    depth,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign depth   = cnt;
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr && !push;
  assign top     = mem[PTR_W'(cnt - CNT_W'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CNT_W'(1);
    end else if (do_pop) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[PTR_W'(cnt)] <= data_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns the BOOT/RUN/FAULT FSM, the next-pc mux and
// BSR/RET decode on the prefetched code word, backed by a hardware return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned INSTR_W     = 22,
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_n,
  input  logic                         HOLD,
  input  logic                         fault_clr,
  input  logic [INSTR_W-1:0]           pr_code,
  output logic [PC_W-1:0]              pc,
  output logic                         ir_load,
  output logic [$clog2(STACK_DEPTH):0] stack_depth,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         fault,
  output logic [1:0]                   fault_code
);

  state_t          state;
  logic            is_ret;
  logic            is_bsr;
  logic            step;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_bsr;
  logic [PC_W-1:0] stack_top;

  // RET has priority over BSR in decode
  assign is_ret  = (pr_code == RET_CODE);
  assign is_bsr  = !is_ret && (pr_code[INSTR_W-1:PC_W] == BSR_OPCODE);
  assign pc_inc  = pc + PC_W'(1);
  assign pc_bsr  = pc + pr_code[PC_W-1:0];

  assign ir_load = (state == RUN) && !HOLD;
  assign step    = ir_load && !fault_clr;
  assign push    = step && is_bsr && !stack_full;
  assign pop     = step && is_ret && !stack_empty;

  ret_stack #(
    .DATA_W (PC_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk     (CLK),
    .rst_n   (RESET_n),
    .clr     (fault_clr),
    .push    (push),
    .pop     (pop),
    .data_in (pc_inc),
    .top     (stack_top),
    .depth   (stack_depth),
    .full    (stack_full),
    .empty   (stack_empty)
  );

  // fault_clr restarts from any state and overrides HOLD and decode
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= BOOT;
      pc         <= '0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else if (fault_clr) begin
      state      <= BOOT;
      pc         <= '0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (!HOLD) begin
            if (is_ret) begin
              if (stack_empty) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_code <= FAULT_UNF;
              end else begin
                pc <= stack_top;
              end
            end else if (is_bsr) begin
              if (stack_full) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_code <= FAULT_OVF;
              end else begin
                pc <= pc_bsr;
              end
            end else begin
              pc <= pc_inc;
            end
          end
        end
        FAULT: state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes hand-computed expectations,
// an independent monitor pops and compares at each falling edge.
module tb_pc_sequencer;

  logic        CLK;
  logic        RESET_n;
  logic        HOLD;
  logic        fault_clr;
  logic [21:0] pr_code;
  logic [9:0]  pc;
  logic        ir_load;
  logic [2:0]  stack_depth;
  logic        stack_full;
  logic        stack_empty;
  logic        fault;
  logic [1:0]  fault_code;

  typedef struct packed {
    int unsigned tag;
    logic [9:0]  pc;
    logic [2:0]  depth;
    logic        ir;
    logic        flt;
    logic [1:0]  fc;
  } exp_t;

  exp_t        q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned tag      = 0;
  event        sample_ev;

  localparam logic [21:0] NOP = 22'h000000;
  localparam logic [21:0] RET = 22'h018000;

  pc_sequencer dut (
    .CLK         (CLK),
    .RESET_n     (RESET_n),
    .HOLD        (HOLD),
    .fault_clr   (fault_clr),
    .pr_code     (pr_code),
    .pc          (pc),
    .ir_load     (ir_load),
    .stack_depth (stack_depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [21:0] bsr(input logic [9:0] off);
    return {12'b011100000000, off};
  endfunction

  task automatic expect_now(input logic [9:0] epc, input logic [2:0] edep,
                            input logic eir, input logic ef, input logic [1:0] efc);
    exp_t e;
    e.tag = tag; e.pc = epc; e.depth = edep; e.ir = eir; e.flt = ef; e.fc = efc;
    q.push_back(e);
    tag++;
  endtask

  // drive one cycle of inputs and record what the outputs must show during it
  task automatic cyc(input logic [21:0] code, input logic hold, input logic clr,
                     input logic rst, input logic [9:0] epc, input logic [2:0] edep,
                     input logic eir, input logic ef, input logic [1:0] efc);
    @(posedge CLK);
    #1;
    RESET_n   = rst;
    HOLD      = hold;
    fault_clr = clr;
    pr_code   = code;
    expect_now(epc, edep, eir, ef, efc);
  endtask

  // monitor
  initial begin
    exp_t e;
    logic exp_full, exp_empty;
    forever begin
      @(negedge CLK or sample_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_full  = (e.depth == 3'd4);
        exp_empty = (e.depth == 3'd0);
        checks++;
        if (pc !== e.pc || stack_depth !== e.depth || ir_load !== e.ir ||
            fault !== e.flt || fault_code !== e.fc ||
            stack_full !== exp_full || stack_empty !== exp_empty) begin
          failures++;
          $display("FAIL step%0d: actual pc=%0d depth=%0d ir_load=%0b fault=%0b code=%b full=%0b empty=%0b required pc=%0d depth=%0d ir_load=%0b fault=%0b code=%b full=%0b empty=%0b",
                   e.tag, pc, stack_depth, ir_load, fault, fault_code, stack_full, stack_empty,
                   e.pc, e.depth, e.ir, e.flt, e.fc, exp_full, exp_empty);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_n = 1'b0; HOLD = 1'b0; fault_clr = 1'b0; pr_code = NOP;

    // reset, boot, sequential run
    cyc(NOP, 0, 0, 0, 10'd0, 3'd0, 0, 0, 2'b00);
    cyc(NOP, 0, 0, 0, 10'd0, 3'd0, 0, 0, 2'b00);
    cyc(NOP, 0, 0, 1, 10'd0, 3'd0, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) cyc(NOP, 0, 0, 1, 10'(i), 3'd0, 1, 0, 2'b00);

    // BSR +10 from 5, RET back to 6
    cyc(bsr(10'h00A), 0, 0, 1, 10'd5,  3'd0, 1, 0, 2'b00);
    cyc(RET,          0, 0, 1, 10'd15, 3'd1, 1, 0, 2'b00);
    for (int p = 6; p < 20; p++) cyc(NOP, 0, 0, 1, 10'(p), 3'd0, 1, 0, 2'b00);

    // negative offset, then jump to 1023 and wrap
    cyc(bsr(10'h3FC), 0, 0, 1, 10'd20,   3'd0, 1, 0, 2'b00);
    cyc(bsr(10'h3EF), 0, 0, 1, 10'd16,   3'd1, 1, 0, 2'b00);
    cyc(NOP,          0, 0, 1, 10'd1023, 3'd2, 1, 0, 2'b00);
    cyc(NOP,          0, 1, 1, 10'd0,    3'd2, 1, 0, 2'b00);
    cyc(NOP,          0, 0, 1, 10'd0,    3'd0, 0, 0, 2'b00);

    // four nested BSRs fill the stack, fifth overflows at pc=40
    cyc(bsr(10'h00A), 0, 0, 1, 10'd0,  3'd0, 1, 0, 2'b00);
    cyc(bsr(10'h00A), 0, 0, 1, 10'd10, 3'd1, 1, 0, 2'b00);
    cyc(bsr(10'h00A), 0, 0, 1, 10'd20, 3'd2, 1, 0, 2'b00);
    cyc(bsr(10'h00A), 0, 0, 1, 10'd30, 3'd3, 1, 0, 2'b00);
    cyc(bsr(10'h00A), 0, 0, 1, 10'd40, 3'd4, 1, 0, 2'b00);
    cyc(NOP,          0, 0, 1, 10'd40, 3'd4, 0, 1, 2'b01);
    cyc(NOP,          0, 0, 1, 10'd40, 3'd4, 0, 1, 2'b01);
    cyc(NOP,          0, 1, 1, 10'd40, 3'd4, 0, 1, 2'b01);
    cyc(NOP,          0, 0, 1, 10'd0,  3'd0, 0, 0, 2'b00);

    // RET on empty stack at pc=7, cleared while HOLD=1
    for (int p = 0; p < 7; p++) cyc(NOP, 0, 0, 1, 10'(p), 3'd0, 1, 0, 2'b00);
    cyc(RET, 0, 0, 1, 10'd7, 3'd0, 1, 0, 2'b00);
    cyc(NOP, 1, 1, 1, 10'd7, 3'd0, 0, 1, 2'b10);
    cyc(NOP, 1, 0, 1, 10'd0, 3'd0, 0, 0, 2'b00);

    // HOLD stalls a pending BSR
    cyc(NOP,          1, 0, 1, 10'd0, 3'd0, 0, 0, 2'b00);
    cyc(bsr(10'h005), 0, 0, 1, 10'd0, 3'd0, 1, 0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(bsr(10'h005), 1, 0, 1, 10'd5, 3'd1, 0, 0, 2'b00);

    // asynchronous reset mid-cycle
    @(negedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    if (pc !== 10'd0 || stack_depth !== 3'd0) begin
      failures++;
      $display("FAIL async reset: actual pc=%0d depth=%0d required pc=0 depth=0", pc, stack_depth);
    end
    expect_now(10'd0, 3'd0, 0, 0, 2'b00);
    ->sample_ev;
    cyc(NOP, 0, 0, 0, 10'd0, 3'd0, 0, 0, 2'b00);
    cyc(NOP, 0, 0, 1, 10'd0, 3'd0, 0, 0, 2'b00);
    cyc(NOP, 0, 0, 1, 10'd0, 3'd0, 1, 0, 2'b00);
    cyc(NOP, 0, 0, 1, 10'd1, 3'd0, 1, 0, 2'b00);

    @(negedge CLK);
    @(negedge CLK);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d expectations never compared", q.size());
    end
    if (checks < 12) begin
      failures++;
      $display("FAIL scoreboard: only %0d comparisons performed", checks);
    end
    if (ir_load !== 1'b1 || fault !== 1'b0) begin
      failures++;
      $display("FAIL final: actual ir_load=%0b fault=%0b required ir_load=1 fault=0", ir_load, fault);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
